alu_multicycle: RTL
===================

Name: alu_multicycle

Overview:
- Parametrised successor to the team's 8-bit combinational ALU. Adds WIDTH generalisation, a 4-bit opcode, XOR/NOR/SLTU, iterative shifts, an iterative shift-add multiplier, and a full NZCV flag set.
- Registered result with valid/ready handshakes on input and output, so the datapath controller can issue single-cycle and multi-cycle ops through one port.
- Legacy 3-bit control codes keep their meaning when opcode bit 3 is 0.

Parameters:
- WIDTH, 8, operand/result width in bits; power of two, at least 4.
- SHW (localparam), clog2(WIDTH), shift-amount width taken from b[SHW-1:0].

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  a, b and alucontrol are valid.
- in_ready  output  1  block accepts an op this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; low SHW bits are the shift amount for shift ops.
- alucontrol  input  4  opcode.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zerocheck  output  1  result == 0.
- neg  output  1  result[WIDTH-1].
- carry  output  1  ADD: carry-out. SUB: no-borrow (a >= b unsigned). All other ops: 0.
- ovf  output  1  signed overflow for ADD/SUB; 0 for all other ops.
- err  output  1  opcode was reserved.

Behaviour:
- Reset: one cycle of reset forces the following.
  - state = IDLE; out_valid, result, all flags and err = 0; in_ready = 1 from the next cycle.
  - Reset mid-operation aborts the op; no result is produced for it.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
  - 0111 SLT (signed): result = sign of the difference XOR ovf, zero-extended.
  - 1000 XOR, 1001 NOR, 1010 SLL, 1011 SRL, 1100 SRA.
  - 1101 MUL: low WIDTH bits of the product.
  - 1110 SLTU: result = 1 when borrow.
  - Reserved (0011, 0100, 0101, 1111): single-cycle, result 0, zerocheck 1, other flags 0, err 1.
- Accept rule: an op is accepted when in_valid && in_ready.
  - in_ready = (state == IDLE) && (!out_valid || out_ready).
- Arithmetic: SUB computes a + ~b + 1. All arithmetic is modulo 2^WIDTH.
- States: IDLE, SHIFT, MUL.
  - IDLE, accepted single-cycle op (logic, ADD, SUB, SLT, SLTU, reserved): result and flags registered at the accept edge; out_valid = 1 the next cycle (latency 1). Back-to-back throughput is 1 op/cycle while out_ready = 1.
  - IDLE, accepted shift with shamt = 0: behaves as a single-cycle op; result = a.
  - IDLE, accepted shift with shamt > 0: load working register with a and counter with shamt; go to SHIFT.
  - SHIFT: shift 1 bit per cycle (SRA replicates the MSB) and decrement the counter. When the counter reaches 0, register result, set out_valid and return to IDLE. out_valid asserts exactly shamt+1 cycles after accept.
  - IDLE, accepted MUL: load multiplicand = a, multiplier = b, accumulator = 0, counter = WIDTH; go to MUL.
  - MUL: each cycle, if multiplier[0] then accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter decrements. After WIDTH iterations, register result, set out_valid and return to IDLE. out_valid asserts WIDTH+1 cycles after accept.
- Output hold: while out_valid && !out_ready, result, flags and err hold stable and in_ready = 0.
  - out_valid clears on the handshake edge unless a new single-cycle op is accepted on the same edge, in which case the new result replaces it.
- in_ready = 0 throughout SHIFT and MUL. Input signals are ignored unless an accept occurs.
- Flag rules:
  - zerocheck and neg are derived from the final registered result for every op.
  - carry and ovf are computed only for ADD and SUB.
  - For shifts and MUL, carry and ovf are 0; bits shifted out and high product bits are discarded.

Decomposition:
- Package alu_pkg: opcode localparams (OP_AND … OP_SLTU), the reserved-code check function, and the state encoding (IDLE/SHIFT/MUL).
- Sub-module alu_core: purely combinational single-cycle datapath (logic ops, add/sub, SLT/SLTU, flag generation), parametrised by WIDTH.
- alu_multicycle contains the FSM, the shift/MUL iteration registers, the handshake logic and the output registers.

Test Plan:
- ADD a=8'h7F b=8'h01 accepted at cycle N -> at N+1: out_valid=1, result=8'h80, neg=1, ovf=1, carry=0, zerocheck=0.
- SUB 8'h05-8'h05 -> result 0, zerocheck=1, carry=1. SLT a=8'h80 b=8'h7F -> result 1. SLTU with the same operands -> result 0.
- SRA a=8'h90 b=8'h03 -> result 8'hF2, out_valid exactly 4 cycles after accept, in_ready=0 in between. SLL with b=0 -> result equals a, latency 1.
- MUL a=8'h0D b=8'h0B -> result 8'h8F at N+9. MUL 8'hFF*8'hFF -> 8'h01.
- Backpressure: hold out_ready=0 for 3 cycles after an ADD result -> result stable, in_ready=0. Then stream 4 single-cycle ops with out_ready=1 -> one result per cycle, in order.
- Reset asserted during MUL iteration 4 -> next cycle out_valid=0, result=0, in_ready=1. Opcode 4'b0011 -> result 0, err=1, zerocheck=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU.
// Contents: opcode constants, FSM state encoding, and helpers that classify
// opcodes as reserved or as shifts.
package alu_pkg;

  // Legacy 3-bit control codes keep their meaning when bit 3 is clear.
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_e;

  // True for the four opcodes that have no operation assigned.
  function automatic logic is_reserved(input logic [3:0] op);
    logic res;
    case (op)
      4'b0011, 4'b0100, 4'b0101, 4'b1111: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  // True for the three iterative shift opcodes.
  function automatic logic is_shift(input logic [3:0] op);
    logic res;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle datapath of the multi-cycle ALU.
// Ports:
//   a, b    : operands
//   op      : 4-bit opcode
//   result  : single-cycle result (shifts only meaningful with zero shift amount)
//   carry   : ADD carry-out / SUB no-borrow, else 0
//   ovf     : signed overflow for ADD/SUB, else 0
//   err     : opcode is reserved
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  logic [WIDTH:0] add_full;
  logic [WIDTH:0] sub_full;
  logic           add_ovf;
  logic           sub_ovf;

  // Adder/subtractor, comparisons and per-opcode result selection.
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    // Subtraction as a + ~b + 1; the carry-out is the no-borrow indication.
    sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
    sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);

    result = {WIDTH{1'b0}};
    carry  = 1'b0;
    ovf    = 1'b0;
    err    = is_reserved(op);

    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_ADD: begin
        result = add_full[WIDTH-1:0];
        carry  = add_full[WIDTH];
        ovf    = add_ovf;
      end
      OP_SUB: begin
        result = sub_full[WIDTH-1:0];
        carry  = sub_full[WIDTH];
        ovf    = sub_ovf;
      end
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, sub_full[WIDTH-1] ^ sub_ovf};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, ~sub_full[WIDTH]};
      // Only taken with a zero shift amount; non-zero amounts iterate.
      OP_SLL, OP_SRL, OP_SRA: result = a;
      // MUL always iterates; this value is never registered.
      OP_MUL:  result = {WIDTH{1'b0}};
      default: result = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes and a registered result.
// Single-cycle ops return one cycle after accept; shifts iterate one bit per
// cycle and MUL iterates shift-add for WIDTH cycles.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake for a, b, alucontrol
//   out_valid / out_ready: output handshake for result and flags
//   result               : registered result
//   zerocheck, neg       : result == 0, result MSB
//   carry, ovf           : ADD/SUB carry (no-borrow) and signed overflow
//   err                  : accepted opcode was reserved
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alucontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zerocheck,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  // One extra bit so the counter can hold WIDTH for MUL.
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MUL = CW'(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;   // shift operand, or multiplicand
  logic [WIDTH-1:0] mplr_q, mplr_d;   // multiplier
  logic [WIDTH-1:0] acc_q, acc_d;     // product accumulator
  logic [3:0]       op_q, op_d;       // shift direction/type
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_ovf;
  logic             core_err;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] acc_next;
  logic             fin;
  logic [WIDTH-1:0] fin_val;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .b      (b),
    .op     (alucontrol),
    .result (core_result),
    .carry  (core_carry),
    .ovf    (core_ovf),
    .err    (core_err)
  );

  assign shamt = b[SHW-1:0];

  // Handshake, next-state and iteration datapath.
  always_comb begin
    in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;

    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    mplr_d      = mplr_q;
    acc_d       = acc_q;
    op_d        = op_q;
    result_d    = result_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    // A held result drops once the consumer takes it.
    out_valid_d = out_valid_q && !out_ready;
    fin         = 1'b0;
    fin_val     = {WIDTH{1'b0}};

    case (op_q)
      OP_SLL:  shift_next = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_next = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  shift_next = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shift_next = work_q;
    endcase

    if (mplr_q[0]) begin
      acc_next = acc_q + work_q;
    end else begin
      acc_next = acc_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (alucontrol == OP_MUL) begin
            work_d  = a;
            mplr_d  = b;
            acc_d   = {WIDTH{1'b0}};
            cnt_d   = CNT_MUL;
            state_d = ST_MUL;
          end else if (is_shift(alucontrol) && (shamt != {SHW{1'b0}})) begin
            work_d  = a;
            op_d    = alucontrol;
            cnt_d   = {1'b0, shamt};
            state_d = ST_SHIFT;
          end else begin
            result_d    = core_result;
            zero_d      = (core_result == {WIDTH{1'b0}});
            neg_d       = core_result[WIDTH-1];
            carry_d     = core_carry;
            ovf_d       = core_ovf;
            err_d       = core_err;
            out_valid_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = shift_next;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          fin     = 1'b1;
          fin_val = shift_next;
        end else begin
          fin = 1'b0;
        end
      end
      ST_MUL: begin
        acc_d  = acc_next;
        work_d = {work_q[WIDTH-2:0], 1'b0};
        mplr_d = {1'b0, mplr_q[WIDTH-1:1]};
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          fin     = 1'b1;
          fin_val = acc_next;
        end else begin
          fin = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Completion of an iterative op: bits shifted out and high product bits
    // are dropped, so carry/ovf are always clear here.
    if (fin) begin
      result_d    = fin_val;
      zero_d      = (fin_val == {WIDTH{1'b0}});
      neg_d       = fin_val[WIDTH-1];
      carry_d     = 1'b0;
      ovf_d       = 1'b0;
      err_d       = 1'b0;
      out_valid_d = 1'b1;
      state_d     = ST_IDLE;
    end else begin
      fin_val = {WIDTH{1'b0}};
    end
  end

  // State, iteration and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CW{1'b0}};
      work_q      <= {WIDTH{1'b0}};
      mplr_q      <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      op_q        <= 4'b0000;
      result_q    <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      mplr_q      <= mplr_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zerocheck = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule
